// File: rtl/rf_ctrl_pkg.sv
// Shared types and constants for the register-file write arbiter.
// The clear sequencer in rf_write_arbiter is built only when RF_CLEAR_EN is defined.
package rf_ctrl_pkg;

  // Controller modes: normal arbitration, or sweeping the register file to zero.
  typedef enum logic {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } state_e;

  // Number of write requesters when the instantiating code does not say otherwise.
  localparam int NREQ_DEFAULT = 2;

  // Round-robin successor of a granted index: one past it, wrapping at n.
  function automatic int rr_next(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin search: grants the first requesting index at or after ptr,
// wrapping around to index 0. Purely combinational, one-hot (or zero) grant.
module rr_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int  NREQ = NREQ_DEFAULT,
  localparam int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant
);

  logic [NREQ-1:0] upper_mask;
  logic [NREQ-1:0] req_hi;
  logic [NREQ-1:0] grant_hi;
  logic [NREQ-1:0] grant_lo;

  // Indices at or above the pointer are searched first.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_mask
    assign upper_mask[gi] = (ptr <= PW'(gi));
  end

  assign req_hi = req & upper_mask;

  // Isolate the lowest set bit of each candidate vector (x & -x).
  assign grant_hi = req_hi & (~req_hi + NREQ'(1));
  assign grant_lo = req & (~req + NREQ'(1));

  // Prefer the wrapped-free candidate; fall back to the lowest requester overall.
  always_comb begin
    grant = (|req_hi) ? grant_hi : grant_lo;
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write arbiter: NREQ requesters compete round-robin for a single
// registered write port. Writes to address 0 are accepted but suppressed.
// Optional feature: define RF_CLEAR_EN to zero addresses 1..Nloc-1 after reset.
module rf_write_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int  Nloc  = 32,
  parameter int  Dbits = 32,
  parameter int  NREQ  = NREQ_DEFAULT,
  localparam int AW    = $clog2(Nloc),
  localparam int GW    = $clog2(NREQ)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*AW-1:0]    req_addr,
  input  logic [NREQ*Dbits-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rf_wr,
  output logic [AW-1:0]         rf_WriteAddr,
  output logic [Dbits-1:0]      rf_WriteData,
  output logic [GW-1:0]         grant_id,
  output logic                  clearing
);

`ifdef RF_CLEAR_EN
  localparam state_e RESET_STATE = CLEAR;
`else
  localparam state_e RESET_STATE = RUN;
`endif

  state_e            state_q, state_d;
  logic [GW-1:0]     ptr_q, ptr_d;
  logic              wr_q, wr_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [Dbits-1:0]  data_q, data_d;
  logic [GW-1:0]     gid_q, gid_d;

  logic [NREQ-1:0]   grant;
  logic [GW-1:0]     grant_idx;
  logic [AW-1:0]     sel_addr;
  logic [Dbits-1:0]  sel_data;
  logic              run_en;
  logic              xfer;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (grant)
  );

  // Ready is gated by reset so nothing looks accepted while reset is held.
  assign run_en    = reset_n && (state_q == RUN);
  assign req_ready = run_en ? grant : '0;
  assign xfer      = |req_ready;

  // Encode the one-hot grant to an index and pick that requester's payload.
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) grant_idx = GW'(i);
    end
  end

  assign sel_addr = req_addr[grant_idx*AW +: AW];
  assign sel_data = req_data[grant_idx*Dbits +: Dbits];

  // Pointer advances past the winner only when a transfer actually happens.
  always_comb begin
    ptr_d = ptr_q;
    if (xfer) ptr_d = GW'(rr_next(int'(grant_idx), NREQ));
  end

`ifdef RF_CLEAR_EN
  logic [AW-1:0] cnt_q, cnt_d;

  // Clear address counter; restarts at 1 whenever reset is applied.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt_q <= AW'(1);
    else          cnt_q <= cnt_d;
  end

  assign clearing = reset_n && (state_q == CLEAR);
`else
  assign clearing = 1'b0;
`endif

  // Next-state and next-output logic; the write strobe defaults to idle
  // while address, data and grant id hold their last values.
  always_comb begin
    state_d = state_q;
    wr_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    gid_d   = gid_q;
`ifdef RF_CLEAR_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      RUN: begin
        if (xfer) begin
          wr_d   = (sel_addr != '0);
          addr_d = sel_addr;
          data_d = sel_data;
          gid_d  = grant_idx;
        end
      end
      CLEAR: begin
`ifdef RF_CLEAR_EN
        wr_d   = 1'b1;
        addr_d = cnt_q;
        data_d = '0;
        cnt_d  = cnt_q + AW'(1);
        if (cnt_q == AW'(Nloc - 1)) state_d = RUN;
`else
        state_d = RUN;
`endif
      end
      default: state_d = RUN;
    endcase
  end

  // State, pointer and registered write port; reset drops any pending write.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RESET_STATE;
      ptr_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      gid_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      gid_q   <= gid_d;
    end
  end

  assign rf_wr        = wr_q;
  assign rf_WriteAddr = addr_q;
  assign rf_WriteData = data_q;
  assign grant_id     = gid_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter (Nloc=32, Dbits=32, NREQ=2).
// The clear-sequence checks are compiled in when RF_CLEAR_EN is defined.
module tb_rf_write_arbiter;

  logic        clock;
  logic        reset_n;
  logic [1:0]  req_valid;
  logic [9:0]  req_addr;
  logic [63:0] req_data;
  logic [1:0]  req_ready;
  logic        rf_wr;
  logic [4:0]  rf_WriteAddr;
  logic [31:0] rf_WriteData;
  logic [0:0]  grant_id;
  logic        clearing;

  int checks   = 0;
  int failures = 0;

  rf_write_arbiter dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .rf_wr        (rf_wr),
    .rf_WriteAddr (rf_WriteAddr),
    .rf_WriteData (rf_WriteData),
    .grant_id     (grant_id),
    .clearing     (clearing)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Requesters must hold their request steady until it is accepted.
  for (genvar g = 0; g < 2; g++) begin : g_hold
    a_hold: assert property (@(posedge clock) disable iff (!reset_n)
      (req_valid[g] && !req_ready[g]) |=>
        (req_valid[g] && $stable(req_addr[g*5 +: 5]) && $stable(req_data[g*32 +: 32])))
      else $error("hold rule broken by requester %0d", g);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [4:0] a0, input logic [31:0] d0,
                       input logic [4:0] a1, input logic [31:0] d1);
    req_valid = v;
    req_addr  = {a1, a0};
    req_data  = {d1, d0};
    $display("txn t=%0t valid=%b r0=(%0d,%h) r1=(%0d,%h)", $time, v, a0, d0, a1, d1);
  endtask

  task automatic edge_wait();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n   = 1'b0;
    req_valid = 2'b11;
    req_addr  = '0;
    req_data  = '0;
    repeat (3) @(posedge clock);
    #1;
    // Reset values, with requests present to show ready is held low.
    check("rst_wr",    rf_wr, 0);
    check("rst_addr",  rf_WriteAddr, 0);
    check("rst_data",  rf_WriteData, 0);
    check("rst_gid",   grant_id, 0);
    check("rst_ready", req_ready, 0);
    check("rst_ptr",   dut.ptr_q, 0);
    check("rst_clr",   clearing, 0);
    req_valid = 2'b00;
    reset_n   = 1'b1;

`ifdef RF_CLEAR_EN
    for (int k = 1; k < 32; k++) begin
      #1;
      check("clr_busy",  clearing, 1);
      check("clr_ready", req_ready, 0);
      edge_wait();
      check("clr_wr",   rf_wr, 1);
      check("clr_addr", rf_WriteAddr, k);
      check("clr_data", rf_WriteData, 0);
    end
    #1;
    check("clr_done", clearing, 0);
`else
    #1;
    check("noclr_run", clearing, 0);
`endif

    // Single requester 0.
    drive(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0);
    #1 check("single_ready", req_ready, 2'b01);
    edge_wait();
    check("single_wr",   rf_wr, 1);
    check("single_addr", rf_WriteAddr, 5);
    check("single_data", rf_WriteData, 32'hDEADBEEF);
    check("single_gid",  grant_id, 0);
    check("single_ptr",  dut.ptr_q, 1);

    // Requester 1 to address 0: accepted, write suppressed.
    drive(2'b10, 5'd0, 32'h0, 5'd0, 32'h1234);
    #1 check("zero_ready", req_ready, 2'b10);
    edge_wait();
    check("zero_wr",   rf_wr, 0);
    check("zero_addr", rf_WriteAddr, 0);
    check("zero_data", rf_WriteData, 32'h1234);
    check("zero_gid",  grant_id, 1);
    check("zero_ptr",  dut.ptr_q, 0);

    // Both requesters valid for six cycles from ptr=0: alternate 0,1,...
    drive(2'b11, 5'd3, 32'hA0A0A0A0, 5'd4, 32'hB1B1B1B1);
    for (int c = 0; c < 6; c++) begin
      #1 check("rr_ready", req_ready, (c % 2 == 0) ? 2'b01 : 2'b10);
      edge_wait();
      check("rr_wr",   rf_wr, 1);
      check("rr_gid",  grant_id, c % 2);
      check("rr_addr", rf_WriteAddr, (c % 2 == 0) ? 3 : 4);
      check("rr_data", rf_WriteData, (c % 2 == 0) ? 32'hA0A0A0A0 : 32'hB1B1B1B1);
    end
    // Requester 0 is still pending; let it complete.
    drive(2'b01, 5'd3, 32'hA0A0A0A0, 5'd0, 32'h0);
    #1 check("tail_ready", req_ready, 2'b01);
    edge_wait();
    check("tail_gid", grant_id, 0);
    check("tail_ptr", dut.ptr_q, 1);

    // Write to address 7, then three idle cycles.
    drive(2'b10, 5'd0, 32'h0, 5'd7, 32'h77);
    #1 check("w7_ready", req_ready, 2'b10);
    edge_wait();
    check("w7_wr",   rf_wr, 1);
    check("w7_addr", rf_WriteAddr, 7);
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      #1 check("idle_ready", req_ready, 0);
      edge_wait();
      check("idle_wr",   rf_wr, 0);
      check("idle_addr", rf_WriteAddr, 7);
      check("idle_data", rf_WriteData, 32'h77);
      check("idle_gid",  grant_id, 1);
      check("idle_ptr",  dut.ptr_q, 0);
    end

    // Pointer at 0 must favour requester 0 when both ask, then serve 1.
    drive(2'b11, 5'd3, 32'hC3, 5'd4, 32'hC4);
    #1 check("ptr0_ready", req_ready, 2'b01);
    edge_wait();
    check("ptr0_gid", grant_id, 0);
    drive(2'b10, 5'd0, 32'h0, 5'd4, 32'hC4);
    #1 check("ptr1_ready", req_ready, 2'b10);
    edge_wait();
    check("ptr1_gid",  grant_id, 1);
    check("ptr1_addr", rf_WriteAddr, 4);

    // Reset while a write is on the port: it must vanish at once.
    drive(2'b01, 5'd9, 32'h99, 5'd0, 32'h0);
    edge_wait();
    check("pre_rst_wr", rf_wr, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_wr",    rf_wr, 0);
    check("mid_rst_addr",  rf_WriteAddr, 0);
    check("mid_rst_data",  rf_WriteData, 0);
    check("mid_rst_ready", req_ready, 0);
    check("mid_rst_ptr",   dut.ptr_q, 0);
    req_valid = 2'b00;
    edge_wait();
    reset_n = 1'b1;

`ifdef RF_CLEAR_EN
    // Reset pulse in the middle of the clear sequence, at cnt=10.
    for (int k = 1; k < 10; k++) begin
      edge_wait();
      check("clr2_addr", rf_WriteAddr, k);
    end
    reset_n = 1'b0;
    #1;
    check("clr2_rst_wr",   rf_wr, 0);
    check("clr2_rst_addr", rf_WriteAddr, 0);
    check("clr2_rst_clr",  clearing, 0);
    edge_wait();
    reset_n = 1'b1;
    #1 check("clr2_restart", clearing, 1);
    edge_wait();
    check("clr2_wr",   rf_wr, 1);
    check("clr2_addr1", rf_WriteAddr, 1);
`else
    #1 check("post_rst_clr", clearing, 0);
    drive(2'b10, 5'd0, 32'h0, 5'd2, 32'h5);
    #1 check("post_rst_ready", req_ready, 2'b10);
    edge_wait();
    check("post_rst_gid", grant_id, 1);
    check("post_rst_wr",  rf_wr, 1);
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 SHALL have parameter Nloc, default 32, number of register-file locations.
REQ-002 SHALL have parameter Dbits, default 32, data width.
REQ-003 SHALL have parameter NREQ, default 2, number of write requesters (2..8).
REQ-004 SHALL have one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port: clock  input  1  sole clock, all state on posedge.
REQ-006 SHALL have port: reset_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port: req_valid  input  NREQ  per-requester write request.
REQ-008 SHALL have port: req_addr  input  NREQ x $clog2(Nloc)  per-requester destination register.
REQ-009 SHALL have port: req_data  input  NREQ x Dbits  per-requester write data.
REQ-010 SHALL have port: req_ready  output  NREQ  per-requester accept; a transfer occurs when valid and ready are both 1.
REQ-011 SHALL have port: rf_wr  output  1  register-file write enable.
REQ-012 SHALL have port: rf_WriteAddr  output  $clog2(Nloc)  register-file write address.
REQ-013 SHALL have port: rf_WriteData  output  Dbits  register-file write data.
REQ-014 SHALL have port: grant_id  output  $clog2(NREQ)  index of the last accepted requester.
REQ-015 SHALL have port: clearing  output  1  high while the clear sequence runs.

Function
REQ-016 SHALL be in state RUN or CLEAR; req_ready SHALL be all-zero in CLEAR.
REQ-017 SHALL, in RUN, assert at most one req_ready bit per cycle, combinationally from req_valid and the priority pointer.
REQ-018 SHALL use round-robin arbitration: search starts at pointer ptr; the first valid index at or after ptr (mod NREQ) is readied.
REQ-019 SHALL update ptr to (granted index + 1) mod NREQ on each transfer; ptr SHALL remain unchanged when there is no transfer.
REQ-020 SHALL register an accepted transfer onto rf_wr/rf_WriteAddr/rf_WriteData/grant_id with a latency of exactly 1 cycle.
REQ-021 SHALL accept a transfer with req_addr==0 but drive rf_wr=0 for it; address and data are still registered.
REQ-022 SHALL drive rf_wr=0 in any cycle following a cycle with no transfer; rf_WriteAddr, rf_WriteData and grant_id hold their previous values.
REQ-023 SHALL sustain one transfer per cycle with no bubble between back-to-back grants.
REQ-024 SHALL require requesters to hold valid, addr and data stable until ready; the bench SHALL check this with an assertion.

Reset
REQ-025 SHALL, while reset_n=0, drive rf_wr=0, rf_WriteAddr=0, rf_WriteData=0, grant_id=0, ptr=0 and req_ready=0.
REQ-026 SHALL, when reset_n is asserted mid-sequence or mid-transfer, abort immediately; the registered write is lost and no partial write is emitted.
REQ-027 SHALL, on reset release, enter CLEAR if RF_CLEAR_EN is defined and RUN otherwise.

Configuration
REQ-028 SHALL compile the clear sequencer only when macro RF_CLEAR_EN is defined.
REQ-029 SHALL, with RF_CLEAR_EN defined, use an address counter cnt starting at 1 in CLEAR; each cycle rf_wr=1, rf_WriteAddr=cnt, rf_WriteData=0 are registered, and cnt increments.
REQ-030 SHALL, with RF_CLEAR_EN defined, move to RUN after the write with cnt=Nloc-1, so clearing is high for exactly Nloc-1 cycles.
REQ-031 SHALL, with RF_CLEAR_EN undefined, tie clearing to 0, implement no counter, and never enter CLEAR.

Structure
REQ-032 SHALL place the state enum (RUN, CLEAR) and the default NREQ constant in a shared package rf_ctrl_pkg.
REQ-033 SHALL place the round-robin search and pointer logic in a sub-module rr_arbiter (parameter NREQ; inputs req and ptr; output one-hot grant).

Verification
REQ-034 SHALL verify: RF_CLEAR_EN on, Nloc=32, reset released -> 31 cycles of clearing=1 with rf_wr=1 at addresses 1..31, data 0, req_ready=0; then clearing=0.
REQ-035 SHALL verify: single requester 0 with addr 5, data 0xDEADBEEF -> ready in the same cycle; next cycle rf_wr=1, addr 5, data 0xDEADBEEF, grant_id=0.
REQ-036 SHALL verify: both requesters continuously valid for 6 cycles from ptr=0 -> grants 0,1,0,1,0,1 with rf_wr=1 every cycle.
REQ-037 SHALL verify: requester 1 writes addr 0, data 0x1234 -> ready=1; next cycle rf_wr=0.
REQ-038 SHALL verify: reset_n pulsed low during clear at cnt=10 -> outputs go to 0 asynchronously; after release, clear restarts at address 1.
REQ-039 SHALL verify: no valid requesters for 3 cycles after a write to addr 7 -> rf_wr=0 while rf_WriteAddr holds 7 and ptr is unchanged.
